not_pipe: RTL and testbench
===========================

// Module: not_pipe
// PURPOSE
//  Parametrised, pipelined bitwise-inversion stage with valid/ready flow control.
//  Generalises the single-bit inverter: WIDTH-bit data, DEPTH register stages,
//  and a per-beat mode (pass / invert-all / invert-masked).
//  Sits between any valid/ready producer and consumer in the datapath.
// PARAMETERS
//  WIDTH  8  data width in bits, >=1
//  DEPTH  2  pipeline stages, >=1; latency with no backpressure = DEPTH cycles
//  LVL_W  $clog2(DEPTH+1)  width of the level output; derived, do not override
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       stage 0 can accept a beat
//  in_data    in   WIDTH   input data
//  in_mode    in   2       00 pass, 01 invert all, 10 invert bits where in_mask=1, 11 reserved (= pass)
//  in_mask    in   WIDTH   bit mask used only when in_mode=10
//  out_valid  out  1       final stage holds a beat
//  out_ready  in   1       consumer accepts the beat
//  out_data   out  WIDTH   transformed data
//  out_parity out  1       see CONFIGURATION
//  level      out  LVL_W   number of occupied stages, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): all stage valid bits 0, all stage data 0.
//    Resulting outputs: out_valid=0, out_data=0, out_parity=0, level=0, in_ready=1.
//  - Transform applied at capture into stage 0:
//    d0 <= in_data ^ (mode==01 ? {WIDTH{1'b1}} : mode==10 ? in_mask : {WIDTH{1'b0}}).
//    Later stages copy data unchanged. The mode is per beat; beats with different
//    modes may be in flight together.
//  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
//  - Stage i advances when it is empty or when stage i+1 advances. The last stage
//    advances when out_ready is high. in_ready = !v[0] | adv[0], a combinational
//    function of out_ready through the chain (no skid).
//  - With out_ready held at 1, the pipeline sustains 1 beat/cycle. A beat accepted
//    at edge N is presented at out_valid after edge N+DEPTH-1 (DEPTH cycles of latency).
//  - Bubbles collapse: an empty stage is filled even while downstream is stalled.
//  - Full: all DEPTH stages valid and out_ready=0 gives in_ready=0; data holds stable.
//  - Simultaneous in and out transfer when full: both occur, and level is unchanged.
//  - out_data/out_valid must not change while out_valid=1 and out_ready=0.
//  - level = registered occupancy: +1 on in-transfer, -1 on out-transfer, unchanged
//    when both occur. It never exceeds DEPTH and never underflows.
//  - Reset asserted mid-stream discards all in-flight beats immediately.
//  - in_data/in_mode/in_mask are ignored when no in-transfer occurs.
// CONFIGURATION
//  - NOT_PIPE_PARITY_EN defined: an extra parity bit travels with each stage.
//    out_parity = ^out_data (1 when out_data has an odd number of ones), computed
//    at stage-0 capture from the transformed data and pipelined with the beat.
//  - NOT_PIPE_PARITY_EN undefined: no parity storage; out_parity is tied to 0.
//  - All other behaviour is identical in both builds.
// TESTING (WIDTH=8, DEPTH=2 unless stated)
//  1 Reset: rst_n=0 at an arbitrary time, asynchronous to clk -> out_valid=0,
//    level=0, in_ready=1 without waiting for a clock edge.
//  2 Modes, out_ready=1: send 8'hA5 mode 00, 8'hA5 mode 01, 8'hA5 mode 10 with
//    mask 8'h0F -> out_data 8'hA5, 8'h5A, 8'hAA on consecutive cycles; each appears
//    2 cycles after its acceptance.
//  3 Backpressure: out_ready=0, push 3 beats -> first 2 accepted, in_ready=0,
//    level=2. Then out_ready=1 -> beats drain in order, third beat accepted the same
//    cycle, and no beat is lost or duplicated.
//  4 Stall stability: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data
//    constant; then random valid/ready over 1000 beats -> output sequence matches a
//    reference-model queue and level equals the model occupancy every cycle.
//  5 Mid-stream reset: level=2, pulse rst_n low for 1 ns between edges -> out_valid
//    falls immediately; after release, the next accepted beat is the first one output.
//  6 NOT_PIPE_PARITY_EN build: 8'h07 mode 00 -> out_parity=1; 8'h07 mode 01
//    (8'hF8) -> 1; 8'h03 mode 00 -> 0. Undefined build: out_parity=0 always.
//    Repeat test 2 with DEPTH=1 and DEPTH=4 -> latency 1 and 4 respectively.

Source files
------------

// File: rtl/not_pipe.sv
// -----------------------------------------------------------------------------
// not_pipe
//   Pipelined bitwise-inversion stage with valid/ready flow control.
//   A beat is transformed once on capture into stage 0 and then copied
//   unchanged through DEPTH register stages:
//     mode 00 : pass
//     mode 01 : invert all bits
//     mode 10 : invert bits where in_mask = 1
//     mode 11 : reserved, behaves as pass
//   Each stage advances when it is empty or when the stage after it advances,
//   so bubbles collapse while the output is stalled. in_ready is a
//   combinational function of out_ready through that chain; there is no skid.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1); latency is DEPTH cycles
//   LVL_W  width of level, derived from DEPTH; leave at its default
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; discards all in-flight beats
//   in_valid   input beat valid
//   in_ready   stage 0 can accept a beat
//   in_data    input data
//   in_mode    per-beat transform select (see above)
//   in_mask    inversion mask, used only with mode 10
//   out_valid  final stage holds a beat
//   out_ready  consumer accepts the beat
//   out_data   transformed data
//   out_parity ^out_data carried with the beat (NOT_PIPE_PARITY_EN), else 0
//   level      number of occupied stages, 0..DEPTH
//
// Build option
//   NOT_PIPE_PARITY_EN : when defined, a parity bit is computed at stage-0
//                        capture and pipelined with each beat; when undefined,
//                        no parity is stored and out_parity is tied to 0.
// -----------------------------------------------------------------------------
module not_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [LVL_W-1:0] level
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] d_in;
  logic             in_fire;
  logic             out_fire;
  logic [LVL_W-1:0] level_q;

  // Transform applied once, at capture into stage 0.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    flip = '0;
    case (in_mode)
      2'b01:   flip = '1;
      2'b10:   flip = in_mask;
      default: flip = '0;
    endcase
    d_in = in_data ^ flip;
  end

  // Advance chain, evaluated from the output back to stage 0. A stage may
  // load when it is empty or when its current beat moves on this cycle.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = !v_q[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = !v_q[i] || adv[i+1];
    end
  end

  assign in_ready  = !v_q[0] || adv[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign level     = level_q;

  // Stage registers. Data only loads alongside a valid beat, so input data is
  // ignored when no in-transfer occurs and idle stages keep their contents.
  // NOTE: the data registers are reset along with the valid bits because
  // out_data is required to read 0 after reset, not just be ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its upstream neighbour's pre-edge value.
      if (adv[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          d_q[0] <= d_in;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            d_q[i] <= d_q[i-1];
          end
        end
      end
    end
  end

  // Occupancy counter; simultaneous in and out transfers cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (in_fire && !out_fire) begin
      level_q <= level_q + LVL_W'(1);
    end else if (out_fire && !in_fire) begin
      level_q <= level_q - LVL_W'(1);
    end
  end

`ifdef NOT_PIPE_PARITY_EN
  // Parity travels with the beat using the same load enables as the data.
  logic [DEPTH-1:0] p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      if (adv[0] && in_valid) begin
        p_q[0] <= ^d_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i] && v_q[i-1]) begin
          p_q[i] <= p_q[i-1];
        end
      end
    end
  end

  assign out_parity = p_q[DEPTH-1];
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_not_pipe.sv
// -----------------------------------------------------------------------------
// tb_not_pipe
//   Directed bench for not_pipe. The main instance uses WIDTH=8, DEPTH=2;
//   two further instances (DEPTH=1, DEPTH=4) share its inputs so the mode
//   burst also shows the latency at other depths. Inputs are driven on the
//   falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_not_pipe;

`ifdef NOT_PIPE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic [7:0] in_mask;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_parity;
  logic [7:0] out_data;
  logic [1:0] level;

  logic       in_ready1, out_valid1, out_parity1;
  logic [7:0] out_data1;
  logic [0:0] level1;

  logic       in_ready4, out_valid4, out_parity4;
  logic [7:0] out_data4;
  logic [2:0] level4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp2 [3] = '{8'hA5, 8'h5A, 8'hAA};
  logic [7:0] st_d [3] = '{8'hA5, 8'hA5, 8'hA5};
  logic [1:0] st_m [3] = '{2'b00, 2'b01, 2'b10};
  logic [7:0] st_k [3] = '{8'h00, 8'h00, 8'h0F};

  logic [7:0] exp6 [3] = '{8'h07, 8'hF8, 8'h03};
  logic       par6 [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] st6_d [3] = '{8'h07, 8'h07, 8'h03};
  logic [1:0] st6_m [3] = '{2'b00, 2'b01, 2'b00};

  not_pipe #(.WIDTH(8), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .level(level)
  );

  not_pipe #(.WIDTH(8), .DEPTH(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_parity(out_parity1), .level(level1)
  );

  not_pipe #(.WIDTH(8), .DEPTH(4)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_parity(out_parity4), .level(level4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m,
                       input logic [7:0] k);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    in_mask  = k;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m,
                                    input logic [7:0] k);
    case (m)
      2'b01:   return ~d;
      2'b10:   return d ^ k;
      default: return d;
    endcase
  endfunction

  // Expected output of the mode burst for an instance of the given depth,
  // sampled after the j-th edge (beat b accepted at edge b).
  task automatic chk_burst(input string tag, input int depth, input int j,
                           input logic v, input logic [7:0] d);
    int k;
    k = j - (depth - 1);
    if (k >= 0 && k < 3) begin
      check($sformatf("%s_valid_e%0d", tag, j), v, 1);
      check($sformatf("%s_data_e%0d", tag, j), d, exp2[k]);
    end else begin
      check($sformatf("%s_valid_e%0d", tag, j), v, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] q [$];
    logic [8:0] front;
    logic [7:0] xd;
    logic [7:0] hold_d;
    logic       stalled;
    logic       in_fire, out_fire;
    int         accepted;
    int         cyc;

    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 2'b00, 8'h00);

    // Reset asserted between clock edges; outputs must clear at once.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_parity", out_parity, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode burst on all three depths, out_ready held high.
    drive(1'b1, st_d[0], st_m[0], st_k[0]);
    for (int j = 0; j < 8; j++) begin
      next_cycle();
      chk_burst("burst_d2", 2, j, out_valid, out_data);
      chk_burst("burst_d1", 1, j, out_valid1, out_data1);
      chk_burst("burst_d4", 4, j, out_valid4, out_data4);
      if (j + 1 < 3) drive(1'b1, st_d[j+1], st_m[j+1], st_k[j+1]);
      else           drive(1'b0, 8'h00, 2'b00, 8'h00);
    end

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    drive(1'b1, 8'hB1, 2'b00, 8'h00);
    next_cycle();
    check("bp_in_ready_1", in_ready, 1);
    drive(1'b1, 8'hB2, 2'b00, 8'h00);
    next_cycle();
    check("bp_level_full", level, 2);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 8'hB1);
    drive(1'b1, 8'hB3, 2'b00, 8'h00);
    next_cycle();
    check("bp_hold_level", level, 2);
    check("bp_hold_data", out_data, 8'hB1);
    check("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    next_cycle();
    check("bp_drain_data_1", out_data, 8'hB2);
    check("bp_level_in_out", level, 2);
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    next_cycle();
    check("bp_drain_data_2", out_data, 8'hB3);
    check("bp_drain_level_2", level, 1);
    next_cycle();
    check("bp_drain_valid_end", out_valid, 0);
    check("bp_drain_level_end", level, 0);

    // Stall stability: two beats held with out_ready low for 5 cycles.
    out_ready = 1'b0;
    drive(1'b1, 8'h3C, 2'b01, 8'h00);
    next_cycle();
    drive(1'b1, 8'h11, 2'b10, 8'hF0);
    next_cycle();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      check($sformatf("stall_valid_%0d", j), out_valid, 1);
      check($sformatf("stall_data_%0d", j), out_data, 8'hC3);
    end
    q.push_back({1'b0 ^ (PAR_EN & (^8'hC3)), 8'hC3});
    q.push_back({1'b0 ^ (PAR_EN & (^8'hE1)), 8'hE1});

    // Random valid/ready against a queue model.
    accepted = 0;
    cyc      = 0;
    stalled  = 1'b0;
    hold_d   = 8'h00;
    while (accepted < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_mask   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        check("rand_stall_valid", out_valid, 1);
        check("rand_stall_data", out_data, hold_d);
      end
      check("rand_in_ready", in_ready, (q.size() < 2) || out_ready);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        check("rand_out_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          front = q.pop_front();
          check("rand_out_data", out_data, front[7:0]);
          check("rand_out_parity", out_parity, front[8]);
        end
      end
      if (in_fire) begin
        xd = xf(in_data, in_mode, in_mask);
        q.push_back({PAR_EN & (^xd), xd});
        accepted++;
      end
      stalled = out_valid && !out_ready;
      hold_d  = out_data;
      next_cycle();
      check("rand_level", level, q.size());
      cyc++;
    end
    check("rand_accepted", accepted, 1000);

    drive(1'b0, 8'h00, 2'b00, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        front = q.pop_front();
        check("drain_data", out_data, front[7:0]);
      end
      next_cycle();
    end
    check("drain_model_empty", q.size(), 0);
    check("drain_level", level, 0);

    // Mid-stream reset with a full pipe.
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 2'b00, 8'h00);
    next_cycle();
    drive(1'b1, 8'h22, 2'b00, 8'h00);
    next_cycle();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    check("mid_pre_level", level, 2);
    check("mid_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #0.5;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_in_ready", in_ready, 1);
    #0.5 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 8'h5D, 2'b01, 8'h00);
    next_cycle();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    check("mid_post_valid_0", out_valid, 0);
    next_cycle();
    check("mid_post_valid_1", out_valid, 1);
    check("mid_post_data", out_data, 8'hA2);
    next_cycle();
    check("mid_post_valid_2", out_valid, 0);

    // Parity burst; out_parity is 0 whenever the parity build is off.
    drive(1'b1, st6_d[0], st6_m[0], 8'h00);
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      if (j >= 1 && j <= 3) begin
        check($sformatf("par_valid_e%0d", j), out_valid, 1);
        check($sformatf("par_data_e%0d", j), out_data, exp6[j-1]);
        check($sformatf("par_bit_e%0d", j), out_parity, PAR_EN & par6[j-1]);
      end else begin
        check($sformatf("par_valid_e%0d", j), out_valid, 0);
      end
      if (j + 1 < 3) drive(1'b1, st6_d[j+1], st6_m[j+1], 8'h00);
      else           drive(1'b0, 8'h00, 2'b00, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
